// File: rtl/ttseq_pkg.sv
// Shared definitions for the truth-table sequencer: FSM state encoding and
// the width helper used to size the settle counter.
package ttseq_pkg;

  typedef enum logic [1:0] {
    TTSEQ_IDLE   = 2'd0,
    TTSEQ_SETTLE = 2'd1,
    TTSEQ_SAMPLE = 2'd2,
    TTSEQ_DONE   = 2'd3
  } ttseq_state_e;

  // Bits needed to hold values 0..v-1, never less than 1.
  function automatic int unsigned ttseq_clog2(input int unsigned v);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(v)) w++;
    return w;
  endfunction

endpackage

// File: rtl/ttseq_settle_timer.sv
// Settle down-counter: loaded with SETTLE-1 when a vector's settle window
// opens, pulses expire on the last settle cycle.
module ttseq_settle_timer
  import ttseq_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = ttseq_clog2(SETTLE);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(SETTLE - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expiring at 1 rather than 0 gives exactly SETTLE-1 cycles in SETTLE.
  assign expire = en && (cnt_q == CW'(1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Walks every input vector of an N_IN-input gate, samples its output after
// SETTLE cycles and scores it against a truth table. Optional first-failure
// report: define TTSEQ_FIRST_FAIL_EN. The table input is named `expected`
// because `expect` is a reserved word.
module truth_table_sequencer
  import ttseq_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2**N_IN-1:0]    expected,
  output logic [N_IN-1:0]       stim,
  input  logic                  dut_y,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_IN:0]         err_count,
  output logic [2**N_IN-1:0]    fail_map
`ifdef TTSEQ_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0]       first_fail,
  output logic                  first_fail_vld
`endif
);

  localparam int unsigned NV = 2**N_IN;
  localparam int unsigned IW = N_IN + 1;
  localparam ttseq_state_e VEC_ENTRY = (SETTLE <= 1) ? TTSEQ_SAMPLE : TTSEQ_SETTLE;

  ttseq_state_e    state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NV-1:0]   exp_q, exp_d;
  logic [IW-1:0]   err_q, err_d;
  logic [NV-1:0]   fail_q, fail_d;

  logic accept, sample, last, mism, expire, tmr_load, tmr_en;

  assign accept = ((state_q == TTSEQ_IDLE) || (state_q == TTSEQ_DONE)) && start;
  assign sample = (state_q == TTSEQ_SAMPLE);
  assign last   = (idx_q == IW'(NV - 1));
  assign mism   = (dut_y !== exp_q[idx_q[N_IN-1:0]]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TTSEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      TTSEQ_IDLE,
      TTSEQ_DONE:   if (start) state_d = VEC_ENTRY;
      TTSEQ_SETTLE: if (expire) state_d = TTSEQ_SAMPLE;
      TTSEQ_SAMPLE: state_d = last ? TTSEQ_DONE : VEC_ENTRY;
      default:      state_d = TTSEQ_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == TTSEQ_SETTLE) || (state_q == TTSEQ_SAMPLE);
    done = (state_q == TTSEQ_DONE);
    pass = done && (err_q == '0);
  end

  assign tmr_load = (state_d == TTSEQ_SETTLE) && (state_q != TTSEQ_SETTLE);
  assign tmr_en   = (state_q == TTSEQ_SETTLE);

  ttseq_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .en     (tmr_en),
    .expire (expire)
  );

  always_comb begin
    idx_d  = idx_q;
    exp_d  = exp_q;
    err_d  = err_q;
    fail_d = fail_q;
    if (accept) begin
      idx_d  = '0;
      exp_d  = expected;
      err_d  = '0;
      fail_d = '0;
    end else if (sample) begin
      if (mism) begin
        fail_d[idx_q[N_IN-1:0]] = 1'b1;
        err_d = err_q + IW'(1);
      end
      if (!last) idx_d = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      exp_q  <= '0;
      err_q  <= '0;
      fail_q <= '0;
    end else begin
      idx_q  <= idx_d;
      exp_q  <= exp_d;
      err_q  <= err_d;
      fail_q <= fail_d;
    end
  end

  // The index stays on the last vector in DONE, so stim holds it there.
  assign stim      = idx_q[N_IN-1:0];
  assign err_count = err_q;
  assign fail_map  = fail_q;

`ifdef TTSEQ_FIRST_FAIL_EN
  logic [N_IN-1:0] ff_q, ff_d;
  logic            ff_vld_q, ff_vld_d;

  // Vectors are visited in ascending order, so the first mismatch is the lowest.
  always_comb begin
    ff_d     = ff_q;
    ff_vld_d = ff_vld_q;
    if (accept) begin
      ff_vld_d = 1'b0;
    end else if (sample && mism && !ff_vld_q) begin
      ff_d     = idx_q[N_IN-1:0];
      ff_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q     <= '0;
      ff_vld_q <= 1'b0;
    end else begin
      ff_q     <= ff_d;
      ff_vld_q <= ff_vld_d;
    end
  end

  assign first_fail     = ff_q;
  assign first_fail_vld = ff_vld_q;
`endif

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer: a 2-input instance (SETTLE=2)
// driving selectable AND/OR/X gates and a 3-input instance (SETTLE=1) on XOR3.
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [3:0] exp_a = '0;
  logic [7:0] exp_b = '0;
  logic [1:0] stim_a;
  logic [2:0] stim_b;
  logic       y_a, y_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [2:0] err_a;
  logic [3:0] fail_a;
  logic [3:0] err_b;
  logic [7:0] fail_b;
  int         gate_sel = 0;
  int         errors = 0;
  int         checks = 0;
`ifdef TTSEQ_FIRST_FAIL_EN
  logic [1:0] ff_a;
  logic       ffv_a;
  logic [2:0] ff_b;
  logic       ffv_b;
`endif

  always #5 clk = ~clk;

  always_comb begin
    case (gate_sel)
      0:       y_a = &stim_a;
      1:       y_a = |stim_a;
      default: y_a = (stim_a == 2'd3) ? 1'bx : &stim_a;
    endcase
  end
  assign y_b = ^stim_b;

  truth_table_sequencer #(.N_IN(2), .SETTLE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .expected(exp_a), .stim(stim_a),
    .dut_y(y_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_map(fail_a)
`ifdef TTSEQ_FIRST_FAIL_EN
    , .first_fail(ff_a), .first_fail_vld(ffv_a)
`endif
  );

  truth_table_sequencer #(.N_IN(3), .SETTLE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .expected(exp_b), .stim(stim_b),
    .dut_y(y_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_map(fail_b)
`ifdef TTSEQ_FIRST_FAIL_EN
    , .first_fail(ff_b), .first_fail_vld(ffv_b)
`endif
  );

  task automatic pulse_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic pulse_b();
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, pass_a, stim_a, err_a, fail_a} !== 13'd0) begin
      errors++;
      $display("FAIL reset_a: got %b want 0", {busy_a, done_a, pass_a, stim_a, err_a, fail_a});
    end
    checks++;
    if ({busy_b, done_b, pass_b, stim_b, err_b, fail_b} !== 18'd0) begin
      errors++;
      $display("FAIL reset_b: got %b want 0", {busy_b, done_b, pass_b, stim_b, err_b, fail_b});
    end
`ifdef TTSEQ_FIRST_FAIL_EN
    checks++;
    if ({ff_a, ffv_a, ff_b, ffv_b} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ff: got %b want 0", {ff_a, ffv_a, ff_b, ffv_b});
    end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_and_pass();
    logic [1:0] ev;
    gate_sel = 0;
    exp_a = 4'b1000;
    pulse_a();
    for (int j = 0; j < 8; j++) begin
      ev = 2'(j / 2);
      checks++;
      if (stim_a !== ev || busy_a !== 1'b1 || done_a !== 1'b0) begin
        errors++;
        $display("FAIL and_seq[%0d]: stim=%0d busy=%b done=%b want stim=%0d busy=1 done=0",
                 j, stim_a, busy_a, done_a, ev);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || pass_a !== 1'b1) begin
      errors++;
      $display("FAIL and_done: done=%b busy=%b pass=%b want 1 0 1", done_a, busy_a, pass_a);
    end
    checks++;
    if (err_a !== 3'd0 || fail_a !== 4'b0000 || stim_a !== 2'd3) begin
      errors++;
      $display("FAIL and_result: err=%0d fail=%b stim=%0d want 0 0000 3", err_a, fail_a, stim_a);
    end
  endtask

  task automatic test_or_fail();
    gate_sel = 1;
    exp_a = 4'b1000;
    pulse_a();
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b1 || stim_a !== 2'd0) begin
      errors++;
      $display("FAIL or_restart: done=%b busy=%b stim=%0d want 0 1 0", done_a, busy_a, stim_a);
    end
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (fail_a !== 4'b0110 || err_a !== 3'd2 || pass_a !== 1'b0 || done_a !== 1'b1) begin
      errors++;
      $display("FAIL or_result: fail=%b err=%0d pass=%b done=%b want 0110 2 0 1",
               fail_a, err_a, pass_a, done_a);
    end
`ifdef TTSEQ_FIRST_FAIL_EN
    checks++;
    if (ff_a !== 2'd1 || ffv_a !== 1'b1) begin
      errors++;
      $display("FAIL or_first_fail: ff=%0d vld=%b want 1 1", ff_a, ffv_a);
    end
`endif
  endtask

  task automatic test_x_output();
    logic       y3;
    logic [3:0] wfail;
    logic [2:0] werr;
    gate_sel = 2;
    exp_a = 4'b1000;
    pulse_a();
    repeat (8) @(posedge clk);
    #1;
    // stim holds vector 3 in DONE; a value that is not exactly 1 must score as a miss.
    y3 = y_a;
    wfail = (y3 !== 1'b1) ? 4'b1000 : 4'b0000;
    werr  = (y3 !== 1'b1) ? 3'd1 : 3'd0;
    checks++;
    if (fail_a !== wfail || err_a !== werr || done_a !== 1'b1) begin
      errors++;
      $display("FAIL x_result: fail=%b err=%0d done=%b want %b %0d 1", fail_a, err_a, done_a, wfail, werr);
    end
`ifdef TTSEQ_FIRST_FAIL_EN
    checks++;
    if (ffv_a !== (y3 !== 1'b1) || (ffv_a === 1'b1 && ff_a !== 2'd3)) begin
      errors++;
      $display("FAIL x_first_fail: ff=%0d vld=%b", ff_a, ffv_a);
    end
`endif
  endtask

  task automatic test_start_ignored();
    logic [1:0] ev;
    gate_sel = 0;
    exp_a = 4'b1000;
    pulse_a();
    for (int j = 0; j < 8; j++) begin
      ev = 2'(j / 2);
      checks++;
      if (stim_a !== ev || busy_a !== 1'b1) begin
        errors++;
        $display("FAIL ign_seq[%0d]: stim=%0d busy=%b want %0d 1", j, stim_a, busy_a, ev);
      end
      start_a = (j == 2) || (j == 7);
      @(posedge clk); #1;
    end
    start_a = 1'b0;
    checks++;
    if (done_a !== 1'b1 || pass_a !== 1'b1 || err_a !== 3'd0 || fail_a !== 4'b0000) begin
      errors++;
      $display("FAIL ign_result: done=%b pass=%b err=%0d fail=%b want 1 1 0 0000",
               done_a, pass_a, err_a, fail_a);
    end
    @(posedge clk); #1;
    checks++;
    if (done_a !== 1'b1 || busy_a !== 1'b0 || stim_a !== 2'd3) begin
      errors++;
      $display("FAIL ign_no_restart: done=%b busy=%b stim=%0d want 1 0 3", done_a, busy_a, stim_a);
    end
  endtask

  task automatic test_reset_midrun();
    gate_sel = 1;
    exp_a = 4'b1000;
    pulse_a();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (stim_a !== 2'd2 || fail_a !== 4'b0010) begin
      errors++;
      $display("FAIL mid_pre: stim=%0d fail=%b want 2 0010", stim_a, fail_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, pass_a, stim_a, err_a, fail_a} !== 13'd0) begin
      errors++;
      $display("FAIL mid_async_reset: got %b want 0", {busy_a, done_a, pass_a, stim_a, err_a, fail_a});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    gate_sel = 0;
    pulse_a();
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (done_a !== 1'b1 || pass_a !== 1'b1 || err_a !== 3'd0 || fail_a !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rerun: done=%b pass=%b err=%0d fail=%b want 1 1 0 0000",
               done_a, pass_a, err_a, fail_a);
    end
  endtask

  task automatic test_xor3();
    exp_b = 8'b10010110;
    pulse_b();
    for (int j = 0; j < 8; j++) begin
      checks++;
      if (stim_b !== 3'(j) || busy_b !== 1'b1 || done_b !== 1'b0) begin
        errors++;
        $display("FAIL xor_seq[%0d]: stim=%0d busy=%b done=%b want %0d 1 0", j, stim_b, busy_b, done_b, j);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (done_b !== 1'b1 || pass_b !== 1'b1 || err_b !== 4'd0 || fail_b !== 8'd0) begin
      errors++;
      $display("FAIL xor_result: done=%b pass=%b err=%0d fail=%b want 1 1 0 0",
               done_b, pass_b, err_b, fail_b);
    end
    exp_b = 8'b10010111;
    pulse_b();
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (fail_b !== 8'b00000001 || err_b !== 4'd1 || pass_b !== 1'b0 || done_b !== 1'b1) begin
      errors++;
      $display("FAIL xor_vec0: fail=%b err=%0d pass=%b done=%b want 00000001 1 0 1",
               fail_b, err_b, pass_b, done_b);
    end
`ifdef TTSEQ_FIRST_FAIL_EN
    checks++;
    if (ff_b !== 3'd0 || ffv_b !== 1'b1) begin
      errors++;
      $display("FAIL xor_first_fail: ff=%0d vld=%b want 0 1", ff_b, ffv_b);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_and_pass();
    test_or_fail();
    test_x_output();
    test_start_ignored();
    test_reset_midrun();
    test_xor3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/truth_table_sequencer.md
# truth_table_sequencer

Self-checking stimulus sequencer for small combinational gates. On `start` it drives every input vector of an N_IN-input gate in ascending binary order, waits a fixed settle time, samples the gate output, and compares it against a caller-supplied expected truth table. It sits directly upstream and downstream of a gate under test in the gates benches: `stim` feeds the gate's inputs and `dut_y` consumes its output. It replaces hand-written per-vector stimulus.

## Interface
- `N_IN`, default 2: gate input count, legal range 1..8.
- `SETTLE`, default 2: cycles each vector is held before sampling, minimum 1.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: run request; accepted only in IDLE or DONE.
- `expect` in 2**N_IN: expected truth table; bit i is the output for input vector i. Captured on the accepted `start`.
- `stim` out N_IN: DUT inputs; bit 0 is the first gate input.
- `dut_y` in 1: DUT output.
- `busy` out 1: run in progress.
- `done` out 1: run complete; held until the next accepted `start`.
- `pass` out 1: all vectors matched; valid while `done`=1.
- `err_count` out N_IN+1: number of mismatching vectors.
- `fail_map` out 2**N_IN: bit i set if vector i mismatched.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE plus `start`: capture `expect`, clear `err_count`/`fail_map`, set index=0, `stim`=0, and go to SETTLE.
- SETTLE: hold `stim` for SETTLE-1 cycles, then go to SAMPLE. With SETTLE=1, go to SAMPLE immediately.
- SAMPLE: one cycle. Compare with case equality (`dut_y !== expect[idx]`); X or Z counts as a mismatch. On mismatch, set `fail_map[idx]` and increment `err_count`.
  - If idx is not the last vector: idx+1, drive the new `stim`, go to SETTLE.
  - Otherwise go to DONE.
- DONE: `busy`=0, `done`=1, `pass`=(`err_count`==0). `stim` holds the last vector.
- `start` while `busy`=1 is ignored, with no restart.
- Index register is N_IN+1 bits wide so that the terminal comparison is exact at N_IN=8. `err_count` cannot overflow (max 2**N_IN), so no saturation is needed.

## Timing
- Reset values: `stim`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_map`=0, state IDLE.
- `start` sampled high at edge k: from edge k `busy`=1, `done`=0, `stim`=0.
- Each vector occupies exactly SETTLE cycles of `stim`. Sampling happens at the last edge of that window.
- `done` rises 2**N_IN × SETTLE cycles after the accepting edge, on the edge after the final sample.
- `rst_n` low mid-run: all outputs return to reset values asynchronously, and the partial results are discarded.
- `start` and the final sample on the same cycle: `start` is ignored because the block is still busy.

## Configuration
- `TTSEQ_FIRST_FAIL_EN` defined: adds outputs `first_fail` (N_IN) and `first_fail_vld` (1), both reset 0.
  - `first_fail` latches the index of the lowest mismatching vector.
  - `first_fail_vld` is set on the first mismatch and cleared on an accepted `start`.
- Not defined: those ports and their registers are absent. All other behaviour is identical.

## Structure
- Package `ttseq_pkg`: state encoding (`TTSEQ_IDLE`, `TTSEQ_SETTLE`, `TTSEQ_SAMPLE`, `TTSEQ_DONE`) and the clog2 helper used for settle-counter width.
- One sub-module, `ttseq_settle_timer`: a down-counter loaded with SETTLE-1 that pulses `expire`. Same reset polarity.

## Test plan
- N_IN=2, SETTLE=2, correct AND gate, `expect`=4'b1000 -> `stim` sequence 0,1,2,3 with 2 cycles each; `done` 8 cycles after `start`; `pass`=1, `err_count`=0, `fail_map`=0.
- Same setup, OR gate wired as DUT, `expect`=4'b1000 -> `fail_map`=4'b0110, `err_count`=2, `pass`=0; with the macro, `first_fail`=1 and `first_fail_vld`=1.
- `dut_y` forced to X for vector 3 with `expect`=4'b1000 -> `fail_map`=4'b1000, `err_count`=1.
- `start` pulsed at cycle 3 of a run -> ignored; run length and results unchanged.
- `rst_n` low during vector 2 -> all outputs 0 at once; a new `start` after release runs a clean full pass.
- N_IN=3, SETTLE=1, XOR-of-3 DUT, `expect`=8'b10010110 -> 8 single-cycle vectors, `done` 8 cycles after `start`, `pass`=1.
